feed_scheduler: RTL and testbench



---
 rtl/feed_scheduler.sv | 137 +++++++++++++
 tb/tb_feed_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/feed_scheduler.sv
// Pet feeder dispense controller: button synchronizer/debouncer, periodic auto-feed
// timer, one-deep request flags and an IDLE/DISPENSE/COOLDOWN motor sequencer.
module feed_scheduler #(
    parameter int unsigned PERIOD          = 1000,
    parameter int unsigned DISPENSE_CYCLES = 50,
    parameter int unsigned COOLDOWN_CYCLES = 100,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       enable,
    output logic       motor_on,
    output logic       busy,
    output logic       last_src,
    output logic [7:0] feed_count
);

    localparam int unsigned TW     = $clog2(PERIOD);
    localparam int unsigned DW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PH_MAX = (DISPENSE_CYCLES > COOLDOWN_CYCLES) ? DISPENSE_CYCLES : COOLDOWN_CYCLES;
    localparam int unsigned PW     = $clog2(PH_MAX + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] DISP_LAST  = PW'(DISPENSE_CYCLES - 1);
    localparam logic [PW-1:0] COOL_LAST  = PW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DISPENSE, COOLDOWN} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] phase, phase_nx;
    logic          sync1, sync2, deb;
    logic [DW-1:0] deb_cnt;
    logic [TW-1:0] timer;
    logic          manual_pend, auto_pend;
    logic          deb_rise, auto_event, accept;

    assign deb_rise   = sync2 && !deb && (deb_cnt == DEB_LAST);
    assign auto_event = enable && (timer == TIMER_LAST);
    assign accept     = (state == IDLE) && (manual_pend || auto_pend);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable)
            timer <= '0;
        else if (timer == TIMER_LAST)
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end

    // A set flag is consumed by accept (a coincident event merges into it);
    // a clear flag takes the new event even on the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            manual_pend <= 1'b0;
            auto_pend   <= 1'b0;
        end else begin
            manual_pend <= manual_pend ? !accept : deb_rise;
            auto_pend   <= !enable ? 1'b0 : (auto_pend ? !accept : auto_event);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            last_src   <= 1'b0;
            feed_count <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            if (accept) begin
                last_src <= manual_pend;
                if (feed_count != 8'd255)
                    feed_count <= feed_count + 8'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = DISPENSE;
                    phase_nx = '0;
                end
            end
            DISPENSE: begin
                if (phase == DISP_LAST) begin
                    state_nx = COOLDOWN;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase + 1'b1;
                end
            end
            COOLDOWN: begin
                if (phase == COOL_LAST) begin
                    state_nx = IDLE;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                phase_nx = '0;
            end
        endcase
    end

    assign motor_on = (state == DISPENSE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_feed_scheduler.sv
// Directed testbench for feed_scheduler with PERIOD=20, DISPENSE=4, COOLDOWN=3, DEBOUNCE=3.
module tb_feed_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b0;
    logic       enable = 1'b0;
    logic       motor_on, busy, last_src;
    logic [7:0] feed_count;

    int n_checks = 0;
    int n_fail   = 0;

    feed_scheduler #(
        .PERIOD(20),
        .DISPENSE_CYCLES(4),
        .COOLDOWN_CYCLES(3),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .enable(enable),
        .motor_on(motor_on),
        .busy(busy),
        .last_src(last_src),
        .feed_count(feed_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int rises;
        logic prev;
        btn = 1'b1;
        enable = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({motor_on, busy, last_src, feed_count} !== 11'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got m=%b b=%b s=%b c=%0d, want all 0",
                         i, motor_on, busy, last_src, feed_count);
            end
        end
        reset = 1'b0;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step();
            if (motor_on && !prev) rises++;
            prev = motor_on;
        end
        n_checks++;
        if (rises !== 1) begin
            n_fail++;
            $display("FAIL reset_release_dispenses: got %0d, want 1", rises);
        end
        n_checks++;
        if (last_src !== 1'b1 || feed_count !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_release_state: got src=%b cnt=%0d, want src=1 cnt=1", last_src, feed_count);
        end
        btn = 1'b0;
    endtask

    task automatic test_manual();
        logic exp_m, exp_b;
        enable = 1'b0;
        btn = 1'b0;
        do_reset();
        btn = 1'b1;
        // Edge k is the first edge after btn rises; motor after k+5..k+8, busy k+5..k+11.
        for (int i = 0; i < 15; i++) begin
            step();
            exp_m = (i >= 5) && (i <= 8);
            exp_b = (i >= 5) && (i <= 11);
            n_checks++;
            if (motor_on !== exp_m || busy !== exp_b) begin
                n_fail++;
                $display("FAIL manual_timing k+%0d: got m=%b b=%b, want m=%b b=%b",
                         i, motor_on, busy, exp_m, exp_b);
            end
            if (i == 9) btn = 1'b0;
        end
        n_checks++;
        if (last_src !== 1'b1 || feed_count !== 8'd1) begin
            n_fail++;
            $display("FAIL manual_result: got src=%b cnt=%0d, want src=1 cnt=1", last_src, feed_count);
        end
    endtask

    task automatic test_glitch();
        enable = 1'b0;
        btn = 1'b0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            btn = (i % 3 != 2);
            step();
            n_checks++;
            if (motor_on !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_motor cycle %0d: got %b, want 0", i, motor_on);
            end
        end
        btn = 1'b0;
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (feed_count !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_count: got cnt=%0d busy=%b, want 0 0", feed_count, busy);
        end
    endtask

    task automatic test_auto();
        int rises;
        logic prev, exp_m;
        enable = 1'b1;
        btn = 1'b0;
        do_reset();
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            step();
            exp_m = (i >= 20) && (((i - 20) % 20) < 4);
            n_checks++;
            if (motor_on !== exp_m) begin
                n_fail++;
                $display("FAIL auto_motor r+%0d: got %b, want %b", i, motor_on, exp_m);
            end
            if (motor_on && !prev) rises++;
            prev = motor_on;
        end
        n_checks++;
        if (rises !== 5 || feed_count !== 8'd5 || last_src !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_result: got rises=%0d cnt=%0d src=%b, want 5 5 0", rises, feed_count, last_src);
        end
    endtask

    task automatic test_coincide();
        enable = 1'b1;
        btn = 1'b0;
        do_reset();
        // Press seen at r+15 so deb rises at r+19, the same edge the timer wraps.
        for (int i = 0; i < 15; i++) step();
        btn = 1'b1;
        for (int i = 15; i < 18; i++) step();
        btn = 1'b0;
        for (int i = 18; i < 21; i++) step();
        n_checks++;
        if (motor_on !== 1'b1 || last_src !== 1'b1 || feed_count !== 8'd1) begin
            n_fail++;
            $display("FAIL coincide_first: got m=%b src=%b cnt=%0d, want 1 1 1", motor_on, last_src, feed_count);
        end
        step();
        btn = 1'b1;
        for (int i = 22; i < 28; i++) step();
        n_checks++;
        if (motor_on !== 1'b0 || busy !== 1'b0 || feed_count !== 8'd1) begin
            n_fail++;
            $display("FAIL coincide_gap r+27: got m=%b b=%b cnt=%0d, want 0 0 1", motor_on, busy, feed_count);
        end
        step();
        n_checks++;
        if (motor_on !== 1'b1 || last_src !== 1'b1 || feed_count !== 8'd2) begin
            n_fail++;
            $display("FAIL coincide_second r+28: got m=%b src=%b cnt=%0d, want 1 1 2", motor_on, last_src, feed_count);
        end
        btn = 1'b0;
    endtask

    task automatic test_saturate_reset();
        int rises;
        logic prev;
        enable = 1'b1;
        btn = 1'b0;
        do_reset();
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 5150; i++) begin
            step();
            if (motor_on && !prev) rises++;
            prev = motor_on;
        end
        n_checks++;
        if (rises !== 257 || feed_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturate: got rises=%0d cnt=%0d, want 257 255", rises, feed_count);
        end
        for (int i = 0; i < 40 && !motor_on; i++) step();
        n_checks++;
        if (motor_on !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_dispense: got motor=%b after timeout, want 1", motor_on);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if ({motor_on, busy, last_src, feed_count} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid_dispense: got m=%b b=%b s=%b c=%0d, want all 0",
                     motor_on, busy, last_src, feed_count);
        end
        reset = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (motor_on !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle cycle %0d: got m=%b b=%b, want 0 0", i, motor_on, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_glitch();
        test_auto();
        test_coincide();
        test_saturate_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
